// File: rtl/pe_bus_arbiter_if.sv
// Bus-arbitration signal bundle between the PE systems and pe_bus_arbiter.
// The slave modport is the arbiter side; the master modport is the PE/memory side.
interface pe_bus_arbiter_if #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned ID_W   = 2
);
    logic [NUM_PE-1:0] bus_request;
    logic              mem_readBus;
    logic              mem_writeBus;
    logic              mem_ackBus;
    logic [NUM_PE-1:0] grant;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic              tx_busy;
    logic              preempt;

    modport slave (
        input  bus_request, mem_readBus, mem_writeBus, mem_ackBus,
        output grant, grant_valid, grant_id, tx_busy, preempt
    );

    modport master (
        output bus_request, mem_readBus, mem_writeBus, mem_ackBus,
        input  grant, grant_valid, grant_id, tx_busy, preempt
    );
endinterface

// File: rtl/pe_bus_arbiter.sv
// Round-robin owner arbitration for the shared global-memory/register bus.
// Ownership is held across an outstanding transaction and bounded by MAX_HOLD when others wait.
module pe_bus_arbiter #(
    parameter int unsigned NUM_PE   = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned ID_W     = 2
) (
    input logic             clk,
    input logic             reset,
    pe_bus_arbiter_if.slave bus
);
    localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_TURN
    } state_t;

    state_t            r_state,    w_state;
    logic [NUM_PE-1:0] r_grant,    w_grant;
    logic [ID_W-1:0]   r_grant_id, w_grant_id;
    logic              r_tx_busy,  w_tx_busy;
    logic              r_preempt,  w_preempt;
    logic [ID_W-1:0]   r_rr_ptr,   w_rr_ptr;
    logic [HC_W-1:0]   r_hold_cnt, w_hold_cnt;

    logic              w_found;
    logic [ID_W-1:0]   w_pick;
    logic [ID_W-1:0]   w_idx;
    logic              w_strobe;
    logic              w_owner_req;
    logic              w_others_req;
    logic              w_release;
    logic              w_forced;

    // First requester at or above rr_ptr, wrapping past NUM_PE-1 back to 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = r_rr_ptr;
        for (int unsigned off = 0; off < NUM_PE; off++) begin
            if (!w_found && bus.bus_request[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
            w_idx = (w_idx == ID_W'(NUM_PE - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign w_strobe     = bus.mem_readBus | bus.mem_writeBus;
    assign w_owner_req  = |(bus.bus_request & r_grant);
    assign w_others_req = |(bus.bus_request & ~r_grant);
    assign w_forced     = w_owner_req && (r_hold_cnt == HC_W'(MAX_HOLD)) && w_others_req;
    // Release only between transactions: nothing outstanding and no new strobe this cycle.
    assign w_release    = (r_state == ST_OWN) && !r_tx_busy && !w_strobe &&
                          (!w_owner_req || w_forced);

    always_comb begin
        w_state    = r_state;
        w_grant    = r_grant;
        w_grant_id = r_grant_id;
        w_tx_busy  = r_tx_busy;
        w_preempt  = 1'b0;
        w_rr_ptr   = r_rr_ptr;
        w_hold_cnt = r_hold_cnt;

        case (r_state)
            ST_IDLE: begin
                w_tx_busy = 1'b0;
                if (w_found) begin
                    w_grant    = NUM_PE'(1) << w_pick;
                    w_grant_id = w_pick;
                    w_hold_cnt = '0;
                    w_state    = ST_OWN;
                end
            end
            ST_OWN: begin
                if (bus.mem_ackBus) begin
                    w_tx_busy = 1'b0;
                end else if (w_strobe) begin
                    w_tx_busy = 1'b1;
                end
                if (r_hold_cnt != HC_W'(MAX_HOLD)) begin
                    w_hold_cnt = r_hold_cnt + HC_W'(1);
                end
                if (w_release) begin
                    w_state    = ST_TURN;
                    w_grant    = '0;
                    w_grant_id = '0;
                    w_tx_busy  = 1'b0;
                    w_preempt  = w_forced;
                    w_rr_ptr   = (r_grant_id == ID_W'(NUM_PE - 1)) ? '0 : r_grant_id + 1'b1;
                end
            end
            ST_TURN: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state    = ST_IDLE;
                w_grant    = '0;
                w_grant_id = '0;
                w_tx_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_tx_busy  <= 1'b0;
            r_preempt  <= 1'b0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_grant    <= w_grant;
            r_grant_id <= w_grant_id;
            r_tx_busy  <= w_tx_busy;
            r_preempt  <= w_preempt;
            r_rr_ptr   <= w_rr_ptr;
            r_hold_cnt <= w_hold_cnt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = |r_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.tx_busy     = r_tx_busy;
    assign bus.preempt     = r_preempt;

    a_grant_onehot0: assert property (@(posedge clk) $onehot0(r_grant));
    a_grant_stable_busy: assert property (@(posedge clk) (reset && r_tx_busy) |=> $stable(r_grant));

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Directed bench for pe_bus_arbiter: reset, single owner, round robin, transaction
// protection, hold-limit preemption, lone requester and reset during a transaction.
module tb_pe_bus_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pe_bus_arbiter_if #(.NUM_PE(4), .ID_W(2)) bus_if ();

    pe_bus_arbiter #(
        .NUM_PE  (4),
        .MAX_HOLD(16),
        .ID_W    (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus_if.bus_request  = 4'b0000;
        bus_if.mem_readBus  = 1'b0;
        bus_if.mem_writeBus = 1'b0;
        bus_if.mem_ackBus   = 1'b0;
        do_reset();
        n_checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.grant_valid !== 1'b0 || bus_if.grant_id !== 2'd0 ||
            bus_if.tx_busy !== 1'b0 || bus_if.preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b valid=%b id=%0d busy=%b pre=%b, want all zero",
                     bus_if.grant, bus_if.grant_valid, bus_if.grant_id, bus_if.tx_busy, bus_if.preempt);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus_if.bus_request = 4'b0100;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0100 || bus_if.grant_id !== 2'd2 || bus_if.grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b id=%0d valid=%b, want 0100 id=2 valid=1",
                     bus_if.grant, bus_if.grant_id, bus_if.grant_valid);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_hold: grant=%b want 0100", bus_if.grant);
        end
        bus_if.bus_request = 4'b0000;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.grant_valid !== 1'b0 || bus_if.grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_turn: grant=%b valid=%b id=%0d want 0000/0/0",
                     bus_if.grant, bus_if.grant_valid, bus_if.grant_id);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle: grant=%b want 0000", bus_if.grant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        int         e;
        reset = 1'b0;
        bus_if.bus_request = 4'b1111;
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            exp_g = 4'b0001 << e;
            n_checks++;
            if (bus_if.grant !== exp_g || bus_if.grant_id !== 2'(e)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: grant=%b id=%0d want %b id=%0d",
                         k, bus_if.grant, bus_if.grant_id, exp_g, e);
            end
            tick();
            tick();
            bus_if.bus_request[e] = 1'b0;
            tick();
            n_checks++;
            if (bus_if.grant !== 4'b0000 || bus_if.preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_turn_%0d: grant=%b pre=%b want 0000 pre=0", k, bus_if.grant, bus_if.preempt);
            end
            bus_if.bus_request[e] = 1'b1;
            tick();
            n_checks++;
            if (bus_if.grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_idle_%0d: grant=%b want 0000", k, bus_if.grant);
            end
            tick();
        end
        bus_if.bus_request = 4'b0000;
    endtask

    task automatic test_tx_protect();
        do_reset();
        bus_if.bus_request = 4'b0010;
        tick();
        // zero-wait access and a stray ack must both leave tx_busy low
        bus_if.mem_readBus = 1'b1;
        bus_if.mem_ackBus  = 1'b1;
        tick();
        n_checks++;
        if (bus_if.tx_busy !== 1'b0 || bus_if.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL tx_zero_wait: busy=%b grant=%b want 0 0010", bus_if.tx_busy, bus_if.grant);
        end
        bus_if.mem_readBus = 1'b0;
        tick();
        n_checks++;
        if (bus_if.tx_busy !== 1'b0 || bus_if.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL tx_stray_ack: busy=%b grant=%b want 0 0010", bus_if.tx_busy, bus_if.grant);
        end
        bus_if.mem_ackBus  = 1'b0;
        bus_if.mem_readBus = 1'b1;
        tick();
        n_checks++;
        if (bus_if.tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_set: busy=%b want 1", bus_if.tx_busy);
        end
        bus_if.mem_readBus = 1'b0;
        bus_if.bus_request = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus_if.grant !== 4'b0010 || bus_if.tx_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL tx_hold_%0d: grant=%b busy=%b want 0010 1", i, bus_if.grant, bus_if.tx_busy);
            end
        end
        bus_if.mem_ackBus = 1'b1;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0010 || bus_if.tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_ack: grant=%b busy=%b want 0010 0", bus_if.grant, bus_if.tx_busy);
        end
        bus_if.mem_ackBus = 1'b0;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_turn: grant=%b busy=%b want 0000 0", bus_if.grant, bus_if.tx_busy);
        end
        tick();
    endtask

    task automatic test_hold_limit();
        int bad;
        do_reset();
        bus_if.bus_request = 4'b0001;
        tick();
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) bus_if.bus_request[2] = 1'b1;
            tick();
            if (bus_if.grant !== 4'b0001 || bus_if.preempt !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_owned: %0d cycles lost PE0 grant or pulsed preempt, want 0", bad);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.preempt !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_preempt: grant=%b pre=%b want 0000 1", bus_if.grant, bus_if.preempt);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_pulse_len: grant=%b pre=%b want 0000 0", bus_if.grant, bus_if.preempt);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0100 || bus_if.grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL hold_next_owner: grant=%b id=%0d want 0100 id=2", bus_if.grant, bus_if.grant_id);
        end
        bus_if.bus_request = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_lone_hog();
        int bad;
        do_reset();
        bus_if.bus_request = 4'b1000;
        tick();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.grant !== 4'b1000 || bus_if.grant_id !== 2'd3 || bus_if.preempt !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hog_hold: %0d bad cycles (lost grant or preempt), want 0", bad);
        end
        bus_if.bus_request = 4'b0000;
        tick();
        bus_if.bus_request = 4'b1000;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL hog_gap: grant=%b pre=%b want 0000 0", bus_if.grant, bus_if.preempt);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b1000 || bus_if.preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL hog_regrant: grant=%b pre=%b want 1000 0", bus_if.grant, bus_if.preempt);
        end
        bus_if.bus_request = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_if.bus_request = 4'b1000;
        tick();
        bus_if.mem_writeBus = 1'b1;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b1000 || bus_if.tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_setup: grant=%b busy=%b want 1000 1", bus_if.grant, bus_if.tx_busy);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.grant_valid !== 1'b0 || bus_if.grant_id !== 2'd0 ||
            bus_if.tx_busy !== 1'b0 || bus_if.preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_clear: grant=%b valid=%b id=%0d busy=%b pre=%b want all zero",
                     bus_if.grant, bus_if.grant_valid, bus_if.grant_id, bus_if.tx_busy, bus_if.preempt);
        end
        reset = 1'b1;
        bus_if.mem_writeBus = 1'b0;
        bus_if.bus_request  = 4'b1001;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0001 || bus_if.grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_regrant: grant=%b id=%0d want 0001 id=0", bus_if.grant, bus_if.grant_id);
        end
        bus_if.bus_request = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_tx_protect();
        test_hold_limit();
        test_lone_hog();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
